// File: rtl/ps2_pkg.sv
// Shared types and constants for the PS/2 keyboard receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        IDLE,
        DATA,
        PARIDAD,
        PARADA
    } ps2_estado_t;

    localparam logic [7:0] BREAK_CODE = 8'hF0;
    localparam int         FRAME_BITS = 11;

    // Odd parity holds when the byte plus its parity bit carry an odd number of ones.
    function automatic logic paridad_ok(input logic [7:0] byte_v, input logic par_v);
        return ^{byte_v, par_v};
    endfunction

endpackage

// File: rtl/ps2_filtro_flanco.sv
// PS/2 pad conditioning: two-flop synchronisers, ps2c glitch filter and a
// registered falling-edge strobe of the filtered clock.
module ps2_filtro_flanco #(
    parameter int FILTER_LEN = 8
) (
    input  logic clk,
    input  logic reset,
    input  logic ps2c,
    input  logic ps2d,
    output logic fall,
    output logic ps2d_s
);

    logic                  c_meta_q;
    logic                  c_sync_q;
    logic                  d_meta_q;
    logic                  d_sync_q;
    logic [FILTER_LEN-1:0] filt_sr_q;
    logic                  filt_q;
    logic                  fall_q;

    // The pad path resets to the idle bus level so that a clock already low
    // when reset is released is still seen as a falling edge.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            c_meta_q  <= 1'b1;
            c_sync_q  <= 1'b1;
            d_meta_q  <= 1'b1;
            d_sync_q  <= 1'b1;
            filt_sr_q <= '1;
            filt_q    <= 1'b1;
            fall_q    <= 1'b0;
        end else begin
            c_meta_q  <= ps2c;
            c_sync_q  <= c_meta_q;
            d_meta_q  <= ps2d;
            d_sync_q  <= d_meta_q;
            filt_sr_q <= {filt_sr_q[FILTER_LEN-2:0], c_sync_q};
            fall_q    <= 1'b0;
            if (&filt_sr_q) begin
                filt_q <= 1'b1;
            end else if (~|filt_sr_q) begin
                filt_q <= 1'b0;
                fall_q <= filt_q;
            end
        end
    end

    assign fall   = fall_q;
    assign ps2d_s = d_sync_q;

endmodule

// File: rtl/ps2_receptor_teclado.sv
// PS/2 keyboard frame receiver: FSM, shift register, parity/stop check and watchdog.
// Define PS2_BREAK_FILTER_EN to turn a break sequence (F0 xx) into a single 8'h00 release code.
module ps2_receptor_teclado
    import ps2_pkg::*;
#(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ps2c,
    input  logic       ps2d,
    output logic [7:0] data_out,
    output logic       dato_listo,
    output logic       error_trama,
    output logic       ocupado
);

    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic              fall;
    logic              ps2d_s;

    ps2_estado_t       state_q;
    logic [2:0]        bit_cnt_q;
    logic [7:0]        shift_q;
    logic              parity_q;
    logic [WD_W-1:0]   wd_q;
    logic [7:0]        data_q;
    logic              listo_q;
    logic              err_q;
`ifdef PS2_BREAK_FILTER_EN
    logic              break_pend_q;
`endif

    logic              frame_ok_d;
    logic              timeout_d;

    ps2_filtro_flanco #(
        .FILTER_LEN (FILTER_LEN)
    ) u_filtro (
        .clk    (clk),
        .reset  (reset),
        .ps2c   (ps2c),
        .ps2d   (ps2d),
        .fall   (fall),
        .ps2d_s (ps2d_s)
    );

    assign frame_ok_d = paridad_ok(shift_q, parity_q) && ps2d_s;
    // A fall in the same cycle always beats the watchdog.
    assign timeout_d  = (state_q != IDLE) && !fall && (wd_q == WD_W'(TIMEOUT_CYC - 1));

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            bit_cnt_q    <= '0;
            shift_q      <= '0;
            parity_q     <= 1'b0;
            wd_q         <= '0;
            data_q       <= 8'h00;
            listo_q      <= 1'b0;
            err_q        <= 1'b0;
`ifdef PS2_BREAK_FILTER_EN
            break_pend_q <= 1'b0;
`endif
        end else begin
            listo_q <= 1'b0;
            err_q   <= 1'b0;

            // The fall cycle itself counts, so the watchdog restarts at 1.
            if (state_q == IDLE) begin
                wd_q <= '0;
            end else if (fall) begin
                wd_q <= WD_W'(1);
            end else begin
                wd_q <= wd_q + 1'b1;
            end

            if (timeout_d) begin
                state_q      <= IDLE;
                err_q        <= 1'b1;
                wd_q         <= '0;
                bit_cnt_q    <= '0;
                shift_q      <= '0;
`ifdef PS2_BREAK_FILTER_EN
                break_pend_q <= 1'b0;
`endif
            end else if (fall) begin
                case (state_q)
                    IDLE: begin
                        if (!ps2d_s) begin
                            state_q   <= DATA;
                            bit_cnt_q <= '0;
                        end
                    end
                    DATA: begin
                        shift_q <= {ps2d_s, shift_q[7:1]};
                        if (bit_cnt_q == 3'd7) begin
                            state_q <= PARIDAD;
                        end else begin
                            bit_cnt_q <= bit_cnt_q + 3'd1;
                        end
                    end
                    PARIDAD: begin
                        parity_q <= ps2d_s;
                        state_q  <= PARADA;
                    end
                    PARADA: begin
                        state_q <= IDLE;
                        if (frame_ok_d) begin
`ifdef PS2_BREAK_FILTER_EN
                            if (break_pend_q) begin
                                break_pend_q <= 1'b0;
                                data_q       <= 8'h00;
                                listo_q      <= 1'b1;
                            end else if (shift_q == BREAK_CODE) begin
                                break_pend_q <= 1'b1;
                            end else begin
                                data_q  <= shift_q;
                                listo_q <= 1'b1;
                            end
`else
                            data_q  <= shift_q;
                            listo_q <= 1'b1;
`endif
                        end else begin
                            err_q        <= 1'b1;
`ifdef PS2_BREAK_FILTER_EN
                            break_pend_q <= 1'b0;
`endif
                        end
                    end
                    default: state_q <= IDLE;
                endcase
            end
        end
    end

    assign data_out    = data_q;
    assign dato_listo  = listo_q;
    assign error_trama = err_q;
    assign ocupado     = (state_q != IDLE);

endmodule

// File: tb/tb_ps2_receptor_teclado.sv
// Directed bench for ps2_receptor_teclado: FILTER_LEN=4, TIMEOUT_CYC=200, 40-clk PS/2 half period.
module tb_ps2_receptor_teclado;
    import ps2_pkg::*;

    localparam int FLEN  = 4;
    localparam int TOUT  = 200;
    localparam int HALF  = 40;
    localparam int LAT   = FLEN + 4;

    logic       clk = 1'b0;
    logic       reset;
    logic       ps2c;
    logic       ps2d;
    logic [7:0] data_out;
    logic       dato_listo;
    logic       error_trama;
    logic       ocupado;

    int n_chk  = 0;
    int n_pass = 0;
    int n_rdy  = 0;
    int n_err  = 0;
    int n_both = 0;
    int rdy_k;
    int err_k;
    logic [7:0] rdy_log [$];

    ps2_receptor_teclado #(
        .FILTER_LEN  (FLEN),
        .TIMEOUT_CYC (TOUT)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .ps2c        (ps2c),
        .ps2d        (ps2d),
        .data_out    (data_out),
        .dato_listo  (dato_listo),
        .error_trama (error_trama),
        .ocupado     (ocupado)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (reset) begin
            if (dato_listo) begin
                n_rdy++;
                rdy_log.push_back(data_out);
                $display("rx   t=%0t data_out=%02h", $time, data_out);
            end
            if (error_trama) begin
                n_err++;
                $display("err  t=%0t error_trama pulse", $time);
            end
            if (dato_listo && error_trama) n_both++;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    // One PS/2 bit cell; records the clk count from pad fall to any output pulse.
    task automatic ps2_bit(input logic b);
        ps2d = b;
        idle(HALF / 2);
        ps2c  = 1'b0;
        rdy_k = 0;
        err_k = 0;
        for (int k = 1; k <= HALF; k++) begin
            @(posedge clk); #1;
            if (dato_listo && rdy_k == 0) rdy_k = k;
            if (error_trama && err_k == 0) err_k = k;
        end
        ps2c = 1'b1;
        idle(HALF / 2);
    endtask

    task automatic send_frame(input logic [7:0] b, input logic par, input logic stp);
        logic [FRAME_BITS-1:0] fr;
        fr = {stp, par, b, 1'b0};
        for (int i = 0; i < FRAME_BITS; i++) ps2_bit(fr[i]);
        idle(20);
    endtask

    task automatic send_good(input logic [7:0] b);
        send_frame(b, ~^b, 1'b1);
    endtask

    initial begin
        int base_r;
        int base_e;
        int cyc_e;
        logic [7:0] v;

        reset = 1'b0;
        ps2c  = 1'b1;
        ps2d  = 1'b1;
        idle(3);
        chk("rst_data", data_out, 8'h00);
        chk("rst_listo", dato_listo, 1'b0);
        chk("rst_err", error_trama, 1'b0);
        chk("rst_ocupado", ocupado, 1'b0);
        reset = 1'b1;
        idle(20);

        // 1: good frame 0x5A
        base_r = n_rdy; base_e = n_err;
        send_good(8'h5A);
        chk("t1_pulses", n_rdy - base_r, 1);
        chk("t1_data", data_out, 8'h5A);
        chk("t1_err", n_err - base_e, 0);
        chk("t1_latency", rdy_k, LAT);

        // 2: 0x16 with bad parity
        base_r = n_rdy; base_e = n_err;
        send_frame(8'h16, 1'b1, 1'b1);
        chk("t2_err", n_err - base_e, 1);
        chk("t2_err_lat", err_k, LAT);
        chk("t2_data", data_out, 8'h5A);
        chk("t2_pulses", n_rdy - base_r, 0);

        // 3: 2-clk glitch while idle, then 0x2E
        base_r = n_rdy;
        ps2c = 1'b0;
        idle(2);
        ps2c = 1'b1;
        idle(30);
        chk("t3_glitch_idle", ocupado, 1'b0);
        send_good(8'h2E);
        chk("t3_data", data_out, 8'h2E);
        chk("t3_pulses", n_rdy - base_r, 1);

        // 4: stall after 5 data bits (byte 0x99), expect timeout
        v = 8'h99;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(v[i]);
        base_e = n_err;
        ps2d = v[4];
        idle(HALF / 2);
        ps2c  = 1'b0;
        cyc_e = 0;
        for (int c = 1; c <= 400; c++) begin
            @(posedge clk); #1;
            if (c == HALF) ps2c = 1'b1;
            if (c == 100) chk("t4_ocupado_stall", ocupado, 1'b1);
            if (error_trama) begin
                cyc_e = c;
                chk("t4_ocupado_after", ocupado, 1'b0);
                break;
            end
        end
        chk("t4_timeout_cyc", cyc_e, FLEN + 3 + TOUT);
        idle(20);
        chk("t4_err_count", n_err - base_e, 1);
        send_good(8'h33);
        chk("t4_data", data_out, 8'h33);

        // 5: reset during data bit 4 of 0x77, then 0x24
        v = 8'h77;
        ps2_bit(1'b0);
        for (int i = 0; i < 4; i++) ps2_bit(v[i]);
        ps2d = v[4];
        idle(HALF / 2);
        ps2c = 1'b0;
        idle(10);
        chk("t5_ocupado_pre", ocupado, 1'b1);
        reset = 1'b0;
        #1;
        chk("t5_rst_data", data_out, 8'h00);
        chk("t5_rst_ocupado", ocupado, 1'b0);
        idle(3);
        reset = 1'b1;
        idle(HALF - 13);
        ps2c = 1'b1;
        idle(HALF / 2);
        for (int i = 5; i < 8; i++) ps2_bit(v[i]);
        ps2_bit(~^v);
        ps2_bit(1'b1);
        idle(300);
        base_r = n_rdy;
        send_good(8'h24);
        chk("t5_data", data_out, 8'h24);
        chk("t5_pulses", n_rdy - base_r, 1);

        // 6: make/break sequence 2E F0 2E
        base_r = n_rdy;
        send_good(8'h2E);
        send_good(8'hF0);
        send_good(8'h2E);
`ifdef PS2_BREAK_FILTER_EN
        chk("t6_pulses", n_rdy - base_r, 2);
        if (n_rdy - base_r == 2) begin
            chk("t6_code0", rdy_log[base_r], 8'h2E);
            chk("t6_code1", rdy_log[base_r + 1], 8'h00);
        end
`else
        chk("t6_pulses", n_rdy - base_r, 3);
        if (n_rdy - base_r == 3) begin
            chk("t6_code0", rdy_log[base_r], 8'h2E);
            chk("t6_code1", rdy_log[base_r + 1], 8'hF0);
            chk("t6_code2", rdy_log[base_r + 2], 8'h2E);
        end
`endif

        chk("never_both", n_both, 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
